// File: rtl/serial_add_sequencer_if.sv
// serial_add_sequencer_if: operand/result handshakes plus the bit-serial link to the sum/carry mux stage
interface serial_add_sequencer_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             cin;
  logic             a_o;
  logic             b_o;
  logic             c_o;
  logic             sel_o;
  logic             o1_i;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
  modport slave (
    input  in_valid, op_a, op_b, cin, o1_i, out_ready,
    output in_ready, a_o, b_o, c_o, sel_o, out_valid, sum, cout, busy
  );
  modport master (
    output in_valid, op_a, op_b, cin, o1_i, out_ready,
    input  in_ready, a_o, b_o, c_o, sel_o, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/serial_add_sequencer.sv
// serial_add_sequencer: LSB-first ripple add driven through an external sum/carry mux stage, two cycles per bit
module serial_add_sequencer #(
  parameter int WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  serial_add_sequencer_if.slave bus
);
  localparam int IW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
  typedef enum logic [1:0] {IDLE, SUM, CARRY, DONE} state_t;
  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sh_a;
  logic [WIDTH-1:0] r_sh_b;
  logic [WIDTH-1:0] r_sh_s;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic [IW-1:0]    r_idx;
  logic             w_active;
  always_ff @(posedge clk)
    r_state <= !rst_n ? IDLE : w_next;
  always_comb begin
    w_next        = r_state;
    w_active      = r_state == SUM || r_state == CARRY;
    bus.in_ready  = r_state == IDLE;
    bus.out_valid = r_state == DONE;
    bus.busy      = r_state != IDLE;
    bus.a_o       = w_active & r_sh_a[0];
    bus.b_o       = w_active & r_sh_b[0];
    bus.c_o       = w_active & r_carry;
    bus.sel_o     = r_state == CARRY;
    case (r_state)
      IDLE:    w_next = bus.in_valid ? SUM : IDLE;
      SUM:     w_next = CARRY;
      CARRY:   w_next = r_idx == LAST ? DONE : SUM;
      DONE:    w_next = bus.out_ready ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  // sum bits enter at the MSB so the LSB-first stream lands in place after WIDTH shifts
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sh_a  <= '0;
      r_sh_b  <= '0;
      r_sh_s  <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_cout  <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: if (bus.in_valid) begin
          r_sh_a  <= bus.op_a;
          r_sh_b  <= bus.op_b;
          r_carry <= bus.cin;
          r_idx   <= '0;
        end
        SUM: r_sh_s <= WIDTH'({bus.o1_i, r_sh_s} >> 1);
        CARRY: begin
          r_carry <= bus.o1_i;
          r_sh_a  <= r_sh_a >> 1;
          r_sh_b  <= r_sh_b >> 1;
          r_idx   <= r_idx + 1'b1;
          if (r_idx == LAST) begin
            r_sum  <= r_sh_s;
            r_cout <= bus.o1_i;
          end
        end
        default: ;
      endcase
    end
  end
  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;
endmodule

// File: tb/tb_serial_add_sequencer.sv
// tb_serial_add_sequencer: directed steps against WIDTH=8 and WIDTH=1 instances, with a behavioural mux stage and result scoreboard
module tb_serial_add_sequencer;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  serial_add_sequencer_if #(.WIDTH(W)) bus ();
  serial_add_sequencer_if #(.WIDTH(1)) bus1 ();
  serial_add_sequencer #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  serial_add_sequencer #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  assign bus.o1_i = bus.sel_o ? ((bus.a_o & bus.b_o) | (bus.a_o & bus.c_o) | (bus.b_o & bus.c_o))
                              : bus.a_o ^ bus.b_o ^ bus.c_o;
  assign bus1.o1_i = bus1.sel_o ? ((bus1.a_o & bus1.b_o) | (bus1.a_o & bus1.c_o) | (bus1.b_o & bus1.c_o))
                                : bus1.a_o ^ bus1.b_o ^ bus1.c_o;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_acc = 0;
  int t_prev = 0;
  logic [W:0]   sbq[$];
  logic [1:0]   sb1[$];
  logic [W-1:0] cur_a;
  logic [W-1:0] cur_b;
  logic [W-1:0] exp_c;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic reset_outputs(input string tag);
    chk({tag, "_in_ready"}, bus.in_ready, 1);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_mux"}, {bus.a_o, bus.b_o, bus.c_o, bus.sel_o}, 0);
    chk({tag, "_sum"}, bus.sum, 0);
    chk({tag, "_cout"}, bus.cout, 0);
  endtask
  task automatic pop_check(input string tag);
    logic [W:0] e;
    chk({tag, "_sb_nonempty"}, sbq.size() > 0, 1);
    e = sbq.size() > 0 ? sbq.pop_front() : 'x;
    chk({tag, "_sum"}, bus.sum, e[W-1:0]);
    chk({tag, "_cout"}, bus.cout, e[W]);
  endtask
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input bit hold_valid);
    int n = 0;
    logic c;
    bus.op_a = a;
    bus.op_b = b;
    bus.cin = ci;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 60) begin
      if (bus.out_valid && bus.out_ready) pop_check("b2b");
      @(negedge clk);
      n++;
    end
    chk("accept_ready", bus.in_ready, 1);
    sbq.push_back({1'b0, a} + {1'b0, b} + ci);
    cur_a = a;
    cur_b = b;
    c = ci;
    for (int i = 0; i < W; i++) begin
      exp_c[i] = c;
      c = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
    end
    @(negedge clk);
    t_acc = cyc;
    if (!hold_valid) bus.in_valid = 1'b0;
  endtask
  task automatic recv(input int hold, input bit drv);
    int n = 0;
    logic [W:0] e;
    while (!bus.out_valid && n < 60) begin
      if (drv) begin
        chk("drv_sel", bus.sel_o, n % 2);
        chk("drv_a", bus.a_o, cur_a[n/2]);
        chk("drv_b", bus.b_o, cur_b[n/2]);
        chk("drv_c", bus.c_o, exp_c[n/2]);
        chk("drv_busy", bus.busy, 1);
      end
      n++;
      @(negedge clk);
    end
    chk("latency", cyc - t_acc, 2 * W);
    e = sbq.size() > 0 ? sbq[0] : 'x;
    for (int i = 0; i < hold; i++) begin
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready, 0);
      chk("bp_sum", bus.sum, e[W-1:0]);
      chk("bp_cout", bus.cout, e[W]);
      @(negedge clk);
    end
    chk("done_out_valid", bus.out_valid, 1);
    pop_check("result");
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("after_out_valid", bus.out_valid, 0);
    chk("after_in_ready", bus.in_ready, 1);
    chk("after_busy", bus.busy, 0);
  endtask
  initial begin
    logic [W-1:0] ba[3];
    logic [W-1:0] bb[3];
    logic         bc[3];
    logic [1:0]   e1;
    ba = '{8'hC3, 8'h7F, 8'h80};
    bb = '{8'hA5, 8'h80, 8'h80};
    bc = '{1'b1, 1'b0, 1'b1};
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.cin = 1'b0;
    bus1.in_valid = 1'b0;
    bus1.out_ready = 1'b0;
    bus1.op_a = '0;
    bus1.op_b = '0;
    bus1.cin = 1'b0;
    repeat (3) @(negedge clk);
    reset_outputs("reset");
    chk("reset_w1", {bus1.in_ready, bus1.out_valid, bus1.busy, bus1.sel_o, bus1.sum, bus1.cout}, 6'b100000);
    rst_n = 1'b1;
    send(8'h5A, 8'h3C, 1'b0, 0);
    recv(0, 1);
    send(8'hFF, 8'h01, 1'b0, 0);
    recv(0, 1);
    send(8'hFF, 8'hFF, 1'b1, 0);
    recv(0, 1);
    send(8'h3E, 8'h21, 1'b1, 0);
    bus.op_a = 8'hAA;
    bus.op_b = 8'h55;
    bus.cin = 1'b1;
    bus.in_valid = 1'b1;
    recv(5, 1);
    send(8'hAA, 8'h55, 1'b1, 0);
    recv(0, 1);
    send(8'h01, 8'h01, 1'b0, 0);
    recv(0, 1);
    // abort during the bit-3 sum cycle; the pending result must never appear
    send(8'h77, 8'h11, 1'b0, 0);
    repeat (6) @(negedge clk);
    chk("midop_bit3_sum", {bus.busy, bus.sel_o, bus.c_o}, {1'b1, 1'b0, exp_c[3]});
    rst_n = 1'b0;
    @(negedge clk);
    reset_outputs("midop_reset");
    sbq.delete();
    rst_n = 1'b1;
    @(negedge clk);
    chk("midop_no_valid", bus.out_valid, 0);
    send(8'h12, 8'h34, 1'b0, 0);
    recv(0, 1);
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      send(ba[i], bb[i], bc[i], 1);
      if (i > 0) chk("b2b_spacing", t_acc - t_prev, 2 * W + 2);
      t_prev = t_acc;
    end
    bus.in_valid = 1'b0;
    recv(0, 1);
    chk("b2b_drained", sbq.size(), 0);
    bus1.op_a = 1'b1;
    bus1.op_b = 1'b1;
    bus1.cin = 1'b1;
    bus1.in_valid = 1'b1;
    chk("w1_in_ready", bus1.in_ready, 1);
    sb1.push_back(2'b11);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    chk("w1_sum_phase", {bus1.a_o, bus1.b_o, bus1.c_o, bus1.sel_o}, 4'b1110);
    @(negedge clk);
    chk("w1_carry_phase", {bus1.a_o, bus1.b_o, bus1.c_o, bus1.sel_o}, 4'b1111);
    @(negedge clk);
    e1 = sb1.size() > 0 ? sb1.pop_front() : 'x;
    chk("w1_out_valid", bus1.out_valid, 1);
    chk("w1_result", {bus1.cout, bus1.sum}, e1);
    bus1.out_ready = 1'b1;
    @(negedge clk);
    bus1.out_ready = 1'b0;
    chk("w1_idle", {bus1.out_valid, bus1.in_ready, bus1.busy}, 3'b010);
    chk("w1_held", {bus1.cout, bus1.sum}, 2'b11);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
